heartbeat_measure_ctrl: RTL and testbench

//  Controller that sequences the beat-period measurement datapath. It synchronises heart_pulse,

---
 rtl/heartbeat_measure_ctrl.sv | 169 ++++++++++++++++
 tb/tb_heartbeat_measure_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/heartbeat_measure_ctrl.sv
// Beat-period measurement controller: pulse sync, ms-tick period timer, EPROM BPM lookup,
// LED/buzzer timing and rate/no-signal alarm. Define HB_ALARM_LATCH_EN for a latched alarm.
module heartbeat_measure_ctrl #(
  parameter int CNT_W        = 11,
  parameter int CLK_PER_TICK = 50000,
  parameter int LED_MS       = 100,
  parameter int MIN_PERIOD   = 250,
  parameter int MAX_PERIOD   = 2000,
  parameter int BPM_LO       = 50,
  parameter int BPM_HI       = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             heart_pulse,
  input  logic             mute,
  input  logic             stop_buzzer,
  output logic [CNT_W-1:0] lut_addr,
  output logic             lut_rd,
  input  logic [10:0]      lut_data,
  output logic [7:0]       bpm,
  output logic             bpm_valid,
  output logic             led,
  output logic             buzzer,
  output logic             alarm,
  output logic             no_signal,
  output logic             artifact,
  output logic [1:0]       fsm_state   // debug: 0 IDLE, 1 COUNT, 2 LOOKUP, 3 LOST
);

  localparam int PRE_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int LED_W = $clog2(LED_MS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_LOOKUP = 2'd2,
    S_LOST   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3, beat;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [CNT_W-1:0] period_cnt;
  logic             at_max, period_ok;
  logic [LED_W-1:0] led_cnt;
  logic             accept, start, reject, go_lost;
  logic             alarm_cond;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= heart_pulse;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign beat = s2 & ~s3;

  always_ff @(posedge clk) begin
    if (rst || tick) pre_cnt <= '0;
    else             pre_cnt <= pre_cnt + PRE_W'(1);
  end

  assign tick      = (pre_cnt == PRE_W'(CLK_PER_TICK - 1));
  assign at_max    = (period_cnt == CNT_W'(MAX_PERIOD));
  assign period_ok = (period_cnt >= CNT_W'(MIN_PERIOD));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // A beat that coincides with the saturated counter is still accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_LOST: if (beat) state_nxt = S_COUNT;
      S_COUNT: begin
        if (beat && period_ok) state_nxt = S_LOOKUP;
        else if (at_max)       state_nxt = S_LOST;
      end
      S_LOOKUP: state_nxt = S_COUNT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    start   = 1'b0;
    reject  = 1'b0;
    go_lost = 1'b0;
    case (state)
      S_IDLE, S_LOST: start = beat;
      S_COUNT: begin
        accept  = beat & period_ok;
        reject  = beat & ~period_ok;
        go_lost = ~beat & at_max;
      end
      S_LOOKUP: reject = beat;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || accept || start)
      period_cnt <= '0;
    else if (tick && (state == S_COUNT || state == S_LOOKUP) && !at_max)
      period_cnt <= period_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                      led_cnt <= '0;
    else if (accept || start)     led_cnt <= LED_W'(LED_MS);
    else if (tick && led_cnt != '0) led_cnt <= led_cnt - LED_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lut_addr  <= '0;
      lut_rd    <= 1'b0;
      artifact  <= 1'b0;
      bpm       <= '0;
      bpm_valid <= 1'b0;
      no_signal <= 1'b0;
    end else begin
      lut_rd   <= accept;
      artifact <= reject;
      if (accept) lut_addr <= period_cnt;
      if (state == S_LOOKUP) begin
        bpm       <= (|lut_data[10:8]) ? 8'd255 : lut_data[7:0];
        bpm_valid <= 1'b1;
      end
      if (go_lost) begin
        no_signal <= 1'b1;
        bpm_valid <= 1'b0;
      end
      if (start) no_signal <= 1'b0;
    end
  end

  assign alarm_cond = no_signal | (bpm_valid & ((bpm < 8'(BPM_LO)) | (bpm > 8'(BPM_HI))));

`ifdef HB_ALARM_LATCH_EN
  // Held until acknowledged while the condition has cleared.
  always_ff @(posedge clk) begin
    if (rst)                        alarm <= 1'b0;
    else if (alarm_cond)            alarm <= 1'b1;
    else if (stop_buzzer)           alarm <= 1'b0;
  end
`else
  logic unused_stop_buzzer;
  assign unused_stop_buzzer = stop_buzzer;

  always_ff @(posedge clk) begin
    if (rst) alarm <= 1'b0;
    else     alarm <= alarm_cond;
  end
`endif

  assign led       = (led_cnt != '0);
  assign buzzer    = ~mute & (led | alarm);
  assign fsm_state = state;

endmodule

// File: tb/tb_heartbeat_measure_ctrl.sv
// Bench for heartbeat_measure_ctrl: directed scenarios plus random beat trains, checked
// against a tick-level beat model and an expected-address queue for LUT reads.
module tb_heartbeat_measure_ctrl;

  localparam int TK      = 4;
  localparam int LED_MS  = 100;
  localparam int MIN_P   = 250;
  localparam int MAX_P   = 2000;

  logic        clk = 1'b0;
  logic        rst, heart_pulse, mute, stop_buzzer;
  logic [10:0] lut_addr, lut_data;
  logic        lut_rd, bpm_valid, led, buzzer, alarm, no_signal, artifact;
  logic [7:0]  bpm;
  logic [1:0]  fsm_state;

  heartbeat_measure_ctrl #(.CLK_PER_TICK(TK)) dut (
    .clk(clk), .rst(rst), .heart_pulse(heart_pulse), .mute(mute), .stop_buzzer(stop_buzzer),
    .lut_addr(lut_addr), .lut_rd(lut_rd), .lut_data(lut_data), .bpm(bpm), .bpm_valid(bpm_valid),
    .led(led), .buzzer(buzzer), .alarm(alarm), .no_signal(no_signal), .artifact(artifact),
    .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // scoreboard: each LUT read must match the next expected period
  logic [10:0] exp_q[$];
  int          art_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (lut_rd) begin
        if (exp_q.size() == 0) check("lut_rd_unexpected", 1, 0);
        else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("lut_addr", 32'(lut_addr), 32'(e));
        end
      end
      if (artifact) art_seen++;
    end
  end

  // reference model state, in ticks and beats
  bit counting  = 0;
  int since     = 0;
  int exp_bpm   = 0;
  bit exp_valid = 0;
  bit exp_nosig = 0;
  int exp_art   = 0;
  int last_t    = 0;
  int act_t     = 0;

  function automatic int bpm_of(input int d);
    return (d > 255) ? 255 : d;
  endfunction

  function automatic bit alarm_of();
    return exp_nosig || (exp_valid && (exp_bpm < 50 || exp_bpm > 150));
  endfunction

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic int align3(input int x);
    return x + ((3 - (x % 4)) + 4) % 4;
  endfunction

  // rise driven at cycle t; the controller acts three edges later
  task automatic do_beat(input int t, input int gap);
    wait_to(t);
    heart_pulse = 1'b1;
    if (counting) begin
      since += gap;
      if (since >= MAX_P) begin
        exp_valid = 0;
        since = 0;
        act_t = t + 3;
      end else if (since < MIN_P) begin
        exp_art++;
      end else begin
        exp_q.push_back(11'(since));
        since     = 0;
        exp_bpm   = bpm_of(int'(lut_data));
        exp_valid = 1;
        act_t     = t + 3;
      end
    end else begin
      since = 0;
      act_t = t + 3;
    end
    counting  = 1;
    exp_nosig = 0;
    last_t    = t;
    repeat (3) begin @(posedge clk); #1; end
    heart_pulse = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("lut_rd_missing", exp_q.size(), 0);
    check("artifact_cnt", art_seen, exp_art);
    check("bpm", bpm, exp_bpm);
    check("bpm_valid", bpm_valid, exp_valid);
    check("no_signal", no_signal, exp_nosig);
`ifndef HB_ALARM_LATCH_EN
    check("alarm", alarm, alarm_of());
`endif
  endtask

  task automatic beat_first();
    do_beat(align3(cyc + 4), 0);
  endtask

  task automatic beat_gap(input int gap, input int data);
    lut_data = 11'(data);
    do_beat(last_t + TK * gap, gap);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_lut_rd"}, lut_rd, 0);
    check({tag, "_lut_addr"}, lut_addr, 0);
    check({tag, "_bpm"}, bpm, 0);
    check({tag, "_bpm_valid"}, bpm_valid, 0);
    check({tag, "_led"}, led, 0);
    check({tag, "_buzzer"}, buzzer, 0);
    check({tag, "_alarm"}, alarm, 0);
    check({tag, "_no_signal"}, no_signal, 0);
    check({tag, "_artifact"}, artifact, 0);
    check({tag, "_fsm_idle"}, fsm_state, 0);
  endtask

  initial begin
    rst = 1'b1; heart_pulse = 1'b0; mute = 1'b0; stop_buzzer = 1'b0; lut_data = 11'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_outputs("reset");

    // mid-COUNT reset, then the first beat must not read the LUT
    beat_first();
    beat_gap(300, 90);
    repeat (200) begin @(posedge clk); #1; end
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    counting = 0; exp_bpm = 0; exp_valid = 0; exp_nosig = 0;
    check_idle_outputs("midreset");
    beat_first();

    // nominal period, LED window and buzzer gating
    beat_gap(750, 80);
    wait_to(act_t + TK * LED_MS - 8);
    check("led_on", led, 1);
    check("buzzer_led", buzzer, 1);
    mute = 1'b1; #1;
    check("buzzer_muted", buzzer, 0);
    mute = 1'b0;
    wait_to(act_t + TK * LED_MS + 8);
    check("led_off", led, 0);
    check("buzzer_off", buzzer, 0);

    // artifact does not retrigger LED; period keeps accumulating
    beat_gap(120, 80);
    check("led_no_retrigger", led, 0);
    beat_gap(680, 80);

    // signal loss and recovery
    wait_to(act_t + TK * MAX_P - 8);
    check("no_signal_early", no_signal, 0);
    wait_to(act_t + TK * MAX_P + 8);
    exp_valid = 0; exp_nosig = 1;
    check("lost_no_signal", no_signal, 1);
    check("lost_bpm_valid", bpm_valid, 0);
    check("lost_bpm_hold", bpm, exp_bpm);
    check("lost_alarm", alarm, 1);
    check("lost_buzzer", buzzer, 1);
    beat_gap(2100, 80);

    // BPM saturation and alarm thresholds
    beat_gap(300, 300);
    beat_gap(300, 150);
    beat_gap(300, 151);
    beat_gap(300, 50);
    beat_gap(300, 49);

    // alarm release behaviour
    beat_gap(300, 40);
    check("alarm_low_rate", alarm, 1);
    beat_gap(300, 80);
`ifdef HB_ALARM_LATCH_EN
    check("alarm_latched", alarm, 1);
    stop_buzzer = 1'b1;
    @(posedge clk); #1;
    stop_buzzer = 1'b0;
    @(posedge clk); #1;
    check("alarm_acked", alarm, 0);
`else
    check("alarm_follows", alarm, 0);
`endif

    // random beat trains
    for (int i = 0; i < 8; i++) begin
      int g, d;
      g = int'($urandom_range(100, 900));
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(256, 2047))
                                      : int'($urandom_range(30, 180));
      beat_gap(g, d);
    end

    repeat (20) begin @(posedge clk); #1; end
    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
